// File: rtl/ux607_uart_pkg.sv
`default_nettype none
// ============================================================================
// ux607_uart_pkg : shared widths, frame constants and frame-building helpers
//                  for the UX607 UART transmitter and receiver.
// Revision: 1.0
// ============================================================================
package ux607_uart_pkg;

  localparam int DATA_W        = 8;
  localparam int DIV_W         = 16;
  // start + data + parity + two stop bits
  localparam int MAX_FRAME_LEN = 1 + DATA_W + 1 + 2;
  localparam int SHIFT_W       = MAX_FRAME_LEN - 1;
  localparam int CNT_W         = $clog2(MAX_FRAME_LEN + 1);
  localparam logic IDLE_LEVEL  = 1'b1;

  // Everything after the start bit; the start bit goes straight to the line register.
  function automatic logic [SHIFT_W-1:0] build_payload(input logic [DATA_W-1:0] data,
                                                       input logic parity_en,
                                                       input logic parity_bit);
    logic [SHIFT_W-1:0] p;
    p = {SHIFT_W{IDLE_LEVEL}};
    p[DATA_W-1:0] = data;
    if (parity_en) p[DATA_W] = parity_bit;
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] frame_len(input logic parity_en, input logic nstop);
    return CNT_W'(DATA_W + 2) + CNT_W'(parity_en) + CNT_W'(nstop);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ux607_uart_baudgen.sv
`default_nettype none
// ============================================================================
// ux607_uart_baudgen : bit-period prescaler; pulses once every divisor+1 enabled
//                      cycles, reloading from the divisor input on load or pulse.
// Revision: 1.0
// ============================================================================
module ux607_uart_baudgen
  import ux607_uart_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             pulse
);

  logic [DIV_W-1:0] count;

  assign pulse = enable && (count == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load || pulse) begin
      count <= divisor;
    end else if (enable) begin
      count <= count - DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ux607_uarttx.sv
`default_nettype none
// ============================================================================
// ux607_uarttx : 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
//                Define UX607_UARTTX_PARITY_EN to add the optional parity bit.
// Revision: 1.0
// ============================================================================
module ux607_uarttx
  import ux607_uart_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_en,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  output logic              io_out,
  input  logic [DIV_W-1:0]  io_div,
  input  logic              io_nstop
`ifdef UX607_UARTTX_PARITY_EN
  ,
  input  logic              io_parity_en,
  input  logic              io_parity_odd
`endif
);

  logic [SHIFT_W-1:0] shifter;
  logic [CNT_W-1:0]   count;
  logic [DIV_W-1:0]   div_q;
  logic               out_q;
  logic               busy;
  logic               accept;
  logic               pulse;
  logic               entering_last;
  logic [DIV_W-1:0]   last_div;
  logic [DIV_W-1:0]   reload;
  logic               par_en;
  logic               par_bit;

`ifdef UX607_UARTTX_PARITY_EN
  assign par_en  = io_parity_en;
  assign par_bit = (^io_in_bits) ^ io_parity_odd;
`else
  assign par_en  = 1'b0;
  assign par_bit = 1'b0;
`endif

  assign busy        = (count != '0);
  assign io_in_ready = io_en && !busy;
  assign accept      = io_in_valid && io_in_ready;
  assign io_out      = out_q;

  // The last stop bit is counted one cycle short so that its final cycle is the
  // ready cycle: a new accept then follows the stop bit with no idle gap.
  assign entering_last = pulse && (count == CNT_W'(2));
  assign last_div      = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign reload        = accept ? io_div : ((count == CNT_W'(2)) ? last_div : div_q);

  ux607_uart_baudgen u_baudgen (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .enable  (busy),
    .divisor (reload),
    .pulse   (pulse)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shifter <= {SHIFT_W{IDLE_LEVEL}};
      count   <= '0;
      div_q   <= '0;
      out_q   <= IDLE_LEVEL;
    end else if (accept) begin
      shifter <= build_payload(io_in_bits, par_en, par_bit);
      count   <= frame_len(par_en, io_nstop);
      div_q   <= io_div;
      out_q   <= ~IDLE_LEVEL;
    end else if (pulse) begin
      shifter <= {IDLE_LEVEL, shifter[SHIFT_W-1:1]};
      out_q   <= shifter[0];
      // With one-cycle bits the shortened last stop bit has no countable cycle left.
      count   <= (entering_last && (div_q == '0)) ? '0 : count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ux607_uarttx.sv
`default_nettype none
// ============================================================================
// tb_ux607_uarttx : directed table, corner sequences and random frames checked
//                   against a bit-list model of the serial line.
// Revision: 1.0
// ============================================================================
module tb_ux607_uarttx;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        io_en;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_in_bits;
  logic        io_out;
  logic [15:0] io_div;
  logic        io_nstop;
`ifdef UX607_UARTTX_PARITY_EN
  logic        io_parity_en;
  logic        io_parity_odd;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        nstop;
    logic        pe;
    logic        po;
    logic [11:0] bits;
    int          len;
    bit          hold;
  } vec_t;

  ux607_uarttx dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_en        (io_en),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out       (io_out),
    .io_div       (io_div),
    .io_nstop     (io_nstop)
`ifdef UX607_UARTTX_PARITY_EN
    ,
    .io_parity_en (io_parity_en),
    .io_parity_odd(io_parity_odd)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Line contents of one frame, bit i is the i-th bit on the wire.
  function automatic void model(input logic [7:0] d, input logic ns, input logic pe,
                                input logic po, output logic [11:0] bits, output int len);
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    len       = 10 + int'(ns);
    if (pe) begin
      bits[9] = (^d) ^ po;
      len++;
    end
  endfunction

  task automatic set_parity(input logic pe, input logic po);
`ifdef UX607_UARTTX_PARITY_EN
    io_parity_en  = pe;
    io_parity_odd = po;
`else
    if (pe || po) $display("note: parity request ignored in this build");
`endif
  endtask

  // Called at a negedge with ready expected high; returns at the negedge of the
  // frame's last cycle (the one where ready should be back).
  task automatic run_frame(input string name, input logic [7:0] d, input logic [15:0] dv,
                           input logic ns, input logic [11:0] eb, input int el,
                           input bit hold, input int drop_en_at);
    int   per, total, bad, first_c;
    logic exp_o, exp_r, got_o, got_r, fo, fr;
    per = int'(dv) + 1;
    total = el * per;
    bad = 0;
    first_c = -1;
    fo = 1'b0;
    fr = 1'b0;
    check($sformatf("%s ready_pre", name), io_in_ready === 1'b1, longint'(io_in_ready), 1);
    io_in_bits  = d;
    io_div      = dv;
    io_nstop    = ns;
    io_in_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      exp_o = eb[(c - 1) / per];
      exp_r = (c == total) && io_en;
      got_o = io_out;
      got_r = io_in_ready;
      if (got_o !== exp_o || got_r !== exp_r) begin
        bad++;
        if (first_c < 0) begin
          first_c = c;
          fo = exp_o;
          fr = exp_r;
          $display("  %s cycle %0d: out=%b ready=%b, want out=%b ready=%b",
                   name, c, got_o, got_r, fo, fr);
        end
      end
      if (c == drop_en_at) io_en = 1'b0;
      if (!hold) io_in_valid = 1'b0;
      io_in_bits = 8'($urandom);
      io_div     = 16'($urandom);
      io_nstop   = 1'($urandom);
    end
    check($sformatf("%s wave_mismatch_cycles", name), bad == 0, bad, 0);
  endtask

  task automatic idle(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (io_out !== 1'b1 || io_in_ready !== io_en) bad++;
    end
    check($sformatf("%s idle_bad_cycles", name), bad == 0, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [11:0] eb;
    int          el;
    logic [7:0]  rd;
    logic [15:0] rdv;
    logic        rns, rpe, rpo;
    bit          rh;

    reset_n     = 1'b0;
    io_en       = 1'b0;
    io_in_valid = 1'b0;
    io_in_bits  = '0;
    io_div      = '0;
    io_nstop    = 1'b0;
    set_parity(1'b0, 1'b0);

    // Reset state
    #12;
    check("reset out", io_out === 1'b1, longint'(io_out), 1);
    check("reset ready_en0", io_in_ready === 1'b0, longint'(io_in_ready), 0);
    io_en = 1'b1;
    #1;
    check("reset ready_en1", io_in_ready === 1'b1, longint'(io_in_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    idle("post_reset", 3);

    // Directed table
    tbl.push_back('{8'h55, 16'd3, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b0});
    tbl.push_back('{8'hA3, 16'd1, 1'b1, 1'b0, 1'b0, 12'h746, 11, 1'b0});
    tbl.push_back('{8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 12'h200, 10, 1'b1});
    tbl.push_back('{8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 12'h3FE, 10, 1'b0});
    tbl.push_back('{8'h3C, 16'd2, 1'b1, 1'b0, 1'b0, 12'h678, 11, 1'b0});
`ifdef UX607_UARTTX_PARITY_EN
    tbl.push_back('{8'h07, 16'd1, 1'b0, 1'b1, 1'b0, 12'h60E, 11, 1'b0});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      set_parity(v.pe, v.po);
      run_frame($sformatf("vec%0d", i), v.data, v.div, v.nstop, v.bits, v.len, v.hold, 0);
      if (!v.hold) idle($sformatf("vec%0d", i), 2);
    end
    set_parity(1'b0, 1'b0);

    // Reset in the middle of a frame, on a cycle where the line is low
    io_in_bits  = 8'h00;
    io_div      = 16'd3;
    io_nstop    = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      io_in_valid = 1'b0;
    end
    check("midrst line_before", io_out === 1'b0, longint'(io_out), 0);
    reset_n = 1'b0;
    #1;
    check("midrst out_async", io_out === 1'b1, longint'(io_out), 1);
    check("midrst ready", io_in_ready === io_en, longint'(io_in_ready), longint'(io_en));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle("midrst_quiet", 30);

    // Enable dropped mid-frame: frame finishes, no new accept until enable returns
    model(8'h96, 1'b0, 1'b0, 1'b0, eb, el);
    run_frame("en_drop", 8'h96, 16'd2, 1'b0, eb, el, 1'b0, 5);
    io_in_valid = 1'b1;
    io_in_bits  = 8'h5A;
    idle("en_low", 8);
    io_en = 1'b1;
    #1;
    model(8'h5A, 1'b1, 1'b0, 1'b0, eb, el);
    run_frame("en_back", 8'h5A, 16'd1, 1'b1, eb, el, 1'b0, 0);
    idle("en_back", 2);

    // Random frames, some back-to-back
    for (int i = 0; i < 16; i++) begin
      rd  = 8'($urandom);
      rdv = 16'($urandom_range(0, 4));
      rns = 1'($urandom);
`ifdef UX607_UARTTX_PARITY_EN
      rpe = 1'($urandom);
      rpo = 1'($urandom);
`else
      rpe = 1'b0;
      rpo = 1'b0;
`endif
      rh = (i < 15) ? 1'($urandom) : 1'b0;
      set_parity(rpe, rpo);
      model(rd, rns, rpe, rpo, eb, el);
      run_frame($sformatf("rnd%0d", i), rd, rdv, rns, eb, el, rh, 0);
      if (!rh) idle($sformatf("rnd%0d", i), 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
